branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Parametrised next-PC generator with an integrated branch history table (BHT) of saturating counters. It owns the fetch PC register and selects each cycle between sequential fetch, JAL target, predicted-taken branch target, load-hazard hold and misprediction recovery. Counters are trained from EX-stage branch resolution, and a flush is raised on every misprediction. It sits between the IF stage (imem/BIOS fetch) and the EX-stage branch comparator, replacing the fixed one-bit predict-and-select PC path.

## Interface
- ENTRIES, 32, number of BHT counters; power of two, 2..1024
- CTR_BITS, 2, counter width; 1..4
- RESET_PC, 32'h4000_0000, PC after reset (BIOS base)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- stall_i  input  1  load hazard; hold PC
- jal_i  input  1  IF pre-decode sees JAL
- jal_target_i  input  32  JAL target
- if_branch_i  input  1  IF pre-decode sees conditional branch
- if_branch_target_i  input  32  branch target computed in IF
- ex_branch_i  input  1  resolved conditional branch present in EX
- ex_pc_i  input  32  PC of the EX branch
- ex_taken_i  input  1  actual outcome
- ex_pred_taken_i  input  1  prediction carried down the pipe with that branch
- ex_target_i  input  32  actual taken target
- pc_o  output  32  current fetch PC (registered)
- predict_taken_o  output  1  prediction for the instruction at pc_o
- flush_o  output  1  misprediction; kill IF/ID contents
- mispredict_cnt_o  output  32  running misprediction count

## Operation
- Index: idx(pc) = pc[log2(ENTRIES)+1:2]; bits [1:0] are ignored.
- predict_taken_o = if_branch_i & counter[idx(pc_o)][CTR_BITS-1]. This output is combinational from the counter read.
- mispredict = ex_branch_i & (ex_taken_i != ex_pred_taken_i). flush_o equals mispredict.
- Next-PC priority (highest first):
  1. mispredict: ex_taken_i ? ex_target_i : ex_pc_i + 4
  2. stall_i: pc_o (hold)
  3. jal_i: jal_target_i
  4. predict_taken_o: if_branch_target_i
  5. otherwise: pc_o + 4
- Mispredict overrides stall: the stalled instruction is on the wrong path and is flushed.
- Training: when ex_branch_i is high, counter[idx(ex_pc_i)] increments on taken and decrements on not-taken, saturating at 0 and 2^CTR_BITS-1. Training happens regardless of stall_i.
- Counter reset value: 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits; 0 for 1 bit).
- Read/write collision: when the same index is read and trained in one cycle, the prediction uses the pre-update value. The update is visible the next cycle.
- mispredict_cnt_o increments by 1 per mispredict cycle and wraps from 2^32-1 to 0.
- All PC arithmetic is 32-bit modulo; +4 from 32'hFFFF_FFFC wraps to 0.
- A JAL in IF is not trained and does not consult the BHT.

## Timing
- Reset (rst=0, asynchronous):
  - pc_o = RESET_PC
  - all counters at their reset value
  - mispredict_cnt_o = 0
  - predict_taken_o and flush_o follow their equations from reset state (flush_o = 0 when ex_branch_i = 0).
- Reset deassertion: first update on the first rising edge with rst=1. Reset mid-operation discards any pending redirect.
- Latency:
  - selected next PC appears on pc_o one cycle after selection
  - flush_o is asserted in the same cycle as the EX resolution
  - redirect PC appears on pc_o on the following edge
- Counter training takes effect at the edge ending the cycle in which ex_branch_i is high.
- No handshakes; every input is sampled every cycle.

## Test plan
- Reset: hold rst=0 with an arbitrary clock and inputs -> pc_o=32'h4000_0000, mispredict_cnt_o=0. After release with no control inputs: pc_o sequence 4000_0000, 4000_0004, 4000_0008.
- Training to taken, ENTRIES=32, CTR_BITS=2: two ex_branch_i taken updates at ex_pc_i=32'h4000_0010 (counter 01->10->11 saturating; a third stays 11). Then pc_o=4000_0010 with if_branch_i=1 and target 4000_0100 -> predict_taken_o=1, next pc_o=4000_0100.
- Mispredict recovery: ex_branch_i=1, ex_pred_taken_i=1, ex_taken_i=0, ex_pc_i=4000_0020, with stall_i=1 and jal_i=1 in the same cycle -> flush_o=1 that cycle, next pc_o=4000_0024, mispredict_cnt_o +1.
- Stall hold: stall_i=1 for 3 cycles at pc_o=4000_0040 -> pc_o stays 4000_0040. A simultaneous ex_branch_i (correctly predicted) still trains its counter, with flush_o=0.
- Aliasing and collision: pc_o=4000_0080 while training ex_pc_i=4000_0000 (same idx for ENTRIES=32) to 10 in the same cycle -> predict_taken_o uses the old 01 (0) that cycle and 1 the next cycle.
- Wrap: drive 2^32 mispredictions by forcing the counter to FFFF_FFFF, then one mispredict -> mispredict_cnt_o=0. pc_o=FFFF_FFFC with no inputs -> next pc_o=0000_0000.

Source files
------------

// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - IF pre-decode, EX resolution and PC outputs of the next-PC unit
// Master drives the fetch/resolve controls; slave is the PC generator.
interface branch_pc_unit_if;
  logic        stall_i;
  logic        jal_i;
  logic [31:0] jal_target_i;
  logic        if_branch_i;
  logic [31:0] if_branch_target_i;
  logic        ex_branch_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_target_i;
  logic [31:0] pc_o;
  logic        predict_taken_o;
  logic        flush_o;
  logic [31:0] mispredict_cnt_o;

  modport master (
    output stall_i, jal_i, jal_target_i, if_branch_i, if_branch_target_i,
           ex_branch_i, ex_pc_i, ex_taken_i, ex_pred_taken_i, ex_target_i,
    input  pc_o, predict_taken_o, flush_o, mispredict_cnt_o
  );

  modport slave (
    input  stall_i, jal_i, jal_target_i, if_branch_i, if_branch_target_i,
           ex_branch_i, ex_pc_i, ex_taken_i, ex_pred_taken_i, ex_target_i,
    output pc_o, predict_taken_o, flush_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - fetch PC register with BHT-based branch prediction and recovery
// Owns pc_o; counters are read at pc_o in IF and trained at ex_pc_i from EX.
module branch_pc_unit #(
  parameter int          ENTRIES  = 32,
  parameter int          CTR_BITS = 2,
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic             clk,
  input  logic             rst,
  branch_pc_unit_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [31:0]         r_pc;
  logic [31:0]         r_mispredict_cnt;
  logic [CTR_BITS-1:0] r_bht [ENTRIES];

  logic [IDX_W-1:0]    w_rd_idx;
  logic [IDX_W-1:0]    w_wr_idx;
  logic                w_predict;
  logic                w_mispredict;
  logic [31:0]         w_next_pc;

  assign w_rd_idx     = r_pc[IDX_W+1:2];
  assign w_wr_idx     = bus.ex_pc_i[IDX_W+1:2];
  // Read happens before the same-edge training write, so a collision sees the old value.
  assign w_predict    = bus.if_branch_i & r_bht[w_rd_idx][CTR_BITS-1];
  assign w_mispredict = bus.ex_branch_i & (bus.ex_taken_i != bus.ex_pred_taken_i);

  // Mispredict outranks stall: the stalled instruction is on the wrong path anyway.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_mispredict) begin
      w_next_pc = bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
    end else if (bus.stall_i) begin
      w_next_pc = r_pc;
    end else if (bus.jal_i) begin
      w_next_pc = bus.jal_target_i;
    end else if (w_predict) begin
      w_next_pc = bus.if_branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc             <= RESET_PC;
      r_mispredict_cnt <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_mispredict) begin
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= CTR_INIT;
      end
    end else if (bus.ex_branch_i) begin
      if (bus.ex_taken_i) begin
        if (r_bht[w_wr_idx] != CTR_MAX) begin
          r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 1'b1;
        end
      end else if (r_bht[w_wr_idx] != '0) begin
        r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 1'b1;
      end
    end
  end

  assign bus.pc_o             = r_pc;
  assign bus.predict_taken_o  = w_predict;
  assign bus.flush_o          = w_mispredict;
  assign bus.mispredict_cnt_o = r_mispredict_cnt;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit against a counter-array model
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_branch_pc_unit;
  localparam int          ENTRIES  = 32;
  localparam int          CTR_BITS = 2;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam int          CMAX     = (1 << CTR_BITS) - 1;
  localparam int          CTHR     = 1 << (CTR_BITS - 1);

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  branch_pc_unit_if bus();

  branch_pc_unit #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  int          m_ctr [ENTRIES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pc_o", bus.pc_o, e.pc);
      chk("predict_taken_o", {31'd0, bus.predict_taken_o}, {31'd0, e.pred});
      chk("flush_o", {31'd0, bus.flush_o}, {31'd0, e.flush});
      chk("mispredict_cnt_o", bus.mispredict_cnt_o, e.cnt);
    end
  end

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input logic r, input logic st, input logic jl, input logic [31:0] jt,
                      input logic ib, input logic [31:0] it, input logic eb,
                      input logic [31:0] ep, input logic et, input logic ept,
                      input logic [31:0] etg);
    exp_t e;
    logic pred, mis;
    @(posedge clk);
    #1;
    rst = r;
    bus.stall_i = st; bus.jal_i = jl; bus.jal_target_i = jt;
    bus.if_branch_i = ib; bus.if_branch_target_i = it;
    bus.ex_branch_i = eb; bus.ex_pc_i = ep; bus.ex_taken_i = et;
    bus.ex_pred_taken_i = ept; bus.ex_target_i = etg;
    if (!r) begin
      m_pc = RESET_PC;
      m_cnt = 0;
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = CTHR - 1;
    end
    pred = ib && (m_ctr[idx_of(m_pc)] >= CTHR);
    mis  = eb && (et != ept);
    e.pc = m_pc; e.pred = pred; e.flush = mis; e.cnt = m_cnt;
    sb_q.push_back(e);
    if (r) begin
      if (eb) begin
        if (et && m_ctr[idx_of(ep)] < CMAX) m_ctr[idx_of(ep)]++;
        else if (!et && m_ctr[idx_of(ep)] > 0) m_ctr[idx_of(ep)]--;
      end
      if (mis) begin
        m_pc = et ? etg : ep + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end else if (st) m_pc = m_pc;
      else if (jl) m_pc = jt;
      else if (pred) m_pc = it;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [31:0] t);
    step(1, 0, 1, t, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_cycle(input logic r);
    step(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
         {$urandom_range(16'h4000, 16'h4000), 14'($urandom), 2'b00},
         ($urandom_range(0, 2) == 0), 32'h4000_0000 + ($urandom_range(0, 255) << 2),
         ($urandom_range(0, 2) == 0), 32'h4000_0000 + ($urandom_range(0, 63) << 2),
         1'($urandom), 1'($urandom), 32'h4000_0000 + ($urandom_range(0, 255) << 2));
  endtask

  initial begin
    bus.stall_i = 0; bus.jal_i = 0; bus.jal_target_i = 0;
    bus.if_branch_i = 0; bus.if_branch_target_i = 0;
    bus.ex_branch_i = 0; bus.ex_pc_i = 0; bus.ex_taken_i = 0;
    bus.ex_pred_taken_i = 0; bus.ex_target_i = 0;
    for (int i = 0; i < 4; i++) rand_cycle(0);
    for (int i = 0; i < 3; i++) idle();
    // Train 0x4000_0010 to strongly taken, then fetch it as a branch.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 32'h4000_0010, 1, 1, 32'h4000_0100);
    jump(32'h4000_0010);
    step(1, 0, 0, 0, 1, 32'h4000_0100, 0, 0, 0, 0, 0);
    idle();
    // Mispredict with stall and JAL competing.
    step(1, 1, 1, 32'h4000_0800, 0, 0, 1, 32'h4000_0020, 0, 1, 32'h4000_0200);
    idle();
    // Stall hold while a correctly predicted branch trains.
    jump(32'h4000_0040);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, 32'h4000_0300, 1, 32'h4000_0044, 1, 1, 0);
    idle();
    // Read/write collision on an aliased index.
    jump(32'h4000_0080);
    step(1, 1, 0, 0, 1, 32'h4000_0400, 1, 32'h4000_0000, 1, 1, 32'h4000_0500);
    step(1, 0, 0, 0, 1, 32'h4000_0400, 0, 0, 0, 0, 0);
    idle();
    // PC wrap.
    jump(32'hFFFF_FFFC);
    idle();
    idle();
    for (int i = 0; i < 300; i++) rand_cycle(1);
    rand_cycle(0);
    for (int i = 0; i < 200; i++) rand_cycle(1);
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_cmp++;
    n_err++;
    $display("FAIL timeout actual=%0t expected=<200000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
